// File: rtl/fifo_burst_drain.sv
// Read-side burst regrouper: pops FIFO words and presents them as BURST_LEN-word bursts on a valid/ready stream.
// Optional macro FIFO_BURST_DRAIN_PARITY_EN adds out_parity, the XOR of out_data, stored per buffered word.
module fifo_burst_drain #(
  parameter int          DATA_W        = 32,
  parameter int          CNT_W         = 10,
  parameter int          BURST_LEN     = 16,
  parameter logic [15:0] BURST_CNT_RST = 16'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_cnt,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
`ifdef FIFO_BURST_DRAIN_PARITY_EN
  output logic              out_parity,
`endif
  output logic              busy,
  output logic [15:0]       burst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  state_t             state_r;
  logic [CNT_W-1:0]   target_r;
  logic [CNT_W-1:0]   issued_r;
  logic [CNT_W-1:0]   cap_idx_r;
  logic               in_flight_r;
  logic               busy_r;
  logic [15:0]        burst_cnt_r;

  logic [DATA_W-1:0]  buf_data_r [2];
  logic               buf_last_r [2];
  logic               head_r;
  logic [1:0]         count_r;

  logic [2:0]         credit_s;
  logic               fifo_rd_s;
  logic               push_s;
  logic               pop_s;
  logic               tail_s;
  logic               cap_last_s;
  logic               last_accept_s;

`ifdef FIFO_BURST_DRAIN_PARITY_EN
  logic               buf_par_r [2];

  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Pop request, buffer handshake and capture-side decode from registered state.
  always_comb begin
    credit_s = {1'b0, count_r} + {2'b00, in_flight_r};
    fifo_rd_s = 1'b0;
    if ((state_r == RUN) && !fifo_empty && (issued_r < target_r) && (credit_s < 3'd2)) begin
      fifo_rd_s = 1'b1;
    end else begin
      fifo_rd_s = 1'b0;
    end
    push_s        = in_flight_r;
    pop_s         = (count_r != 2'd0) && out_ready;
    tail_s        = head_r ^ count_r[0];
    cap_last_s    = (cap_idx_r == (target_r - CNT_W'(1)));
    last_accept_s = pop_s && buf_last_r[head_r];
  end

  assign fifo_rd   = fifo_rd_s;
  assign out_valid = (count_r != 2'd0);
  assign out_data  = buf_data_r[head_r];
  assign out_last  = out_valid && buf_last_r[head_r];
  assign busy      = busy_r;
  assign burst_cnt = burst_cnt_r;
`ifdef FIFO_BURST_DRAIN_PARITY_EN
  assign out_parity = buf_par_r[head_r];
`endif

  // Burst sequencer: target latch, issue/capture counters and burst completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      target_r    <= '0;
      issued_r    <= '0;
      cap_idx_r   <= '0;
      in_flight_r <= 1'b0;
      busy_r      <= 1'b0;
      burst_cnt_r <= BURST_CNT_RST;
    end else begin
      in_flight_r <= fifo_rd_s;
      if (fifo_rd_s) begin
        issued_r <= issued_r + CNT_W'(1);
      end
      if (in_flight_r) begin
        cap_idx_r <= cap_idx_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          // Occupancy cannot fall during a burst, so the target is latched once here.
          if (fifo_cnt >= BURST_LEN_C) begin
            state_r   <= RUN;
            target_r  <= BURST_LEN_C;
            issued_r  <= '0;
            cap_idx_r <= '0;
            busy_r    <= 1'b1;
          end else if (flush && (fifo_cnt != '0)) begin
            state_r   <= RUN;
            target_r  <= fifo_cnt;
            issued_r  <= '0;
            cap_idx_r <= '0;
            busy_r    <= 1'b1;
          end
        end
        RUN: begin
          if (issued_r == target_r) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_accept_s) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            burst_cnt_r <= burst_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer; a capture and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r        <= 1'b0;
      count_r       <= 2'd0;
      buf_data_r[0] <= '0;
      buf_data_r[1] <= '0;
      buf_last_r[0] <= 1'b0;
      buf_last_r[1] <= 1'b0;
`ifdef FIFO_BURST_DRAIN_PARITY_EN
      buf_par_r[0]  <= 1'b0;
      buf_par_r[1]  <= 1'b0;
`endif
    end else begin
      if (push_s) begin
        buf_data_r[tail_s] <= fifo_data;
        buf_last_r[tail_s] <= cap_last_s;
`ifdef FIFO_BURST_DRAIN_PARITY_EN
        buf_par_r[tail_s]  <= parity_f(fifo_data);
`endif
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue-based FIFO model feeds the DUT, and expected bursts are
// derived by chunking the preloaded words into BURST_LEN groups (partial final group under flush).
module tb_fifo_burst_drain;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 10;
  localparam int BL     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic [15:0]       burst_cnt;
`ifdef FIFO_BURST_DRAIN_PARITY_EN
  logic              out_parity;
  logic              out_parity1;
`endif

  logic              rst1;
  logic              fifo_rd1;
  logic [DATA_W-1:0] out_data1;
  logic              out_valid1;
  logic              out_ready1;
  logic              out_last1;
  logic              busy1;
  logic [15:0]       burst_cnt1;

  always #5 clk = ~clk;

  fifo_burst_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_cnt(fifo_cnt), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
`ifdef FIFO_BURST_DRAIN_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy(busy), .burst_cnt(burst_cnt)
  );

  // Single-word bursts fed from an always-available FIFO, burst counter starting close to wrap.
  fifo_burst_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(1), .BURST_CNT_RST(16'hFFFA)) dut1 (
    .clk(clk), .rst(rst1), .fifo_empty(1'b0), .fifo_cnt(10'd1), .fifo_data(32'h0000_005A),
    .fifo_rd(fifo_rd1), .flush(1'b0), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1),
`ifdef FIFO_BURST_DRAIN_PARITY_EN
    .out_parity(out_parity1),
`endif
    .busy(busy1), .burst_cnt(burst_cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] fifo_q [$];
  logic [DATA_W:0]   exp_q  [$];
  int                buf_m, inflight_m, cyc_no, run_cyc;
  logic              pend_first, prev_valid, prev_ready, busy_prev;
  logic [DATA_W-1:0] prev_data;
  logic [5:0]        ready_pat = 6'b101001;
  logic [15:0]       exp1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic upd_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_cnt   = CNT_W'(fifo_q.size());
  endtask

  task automatic load(input int n, input logic [31:0] base, input bit rnd);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom() : base + 32'(i);
      fifo_q.push_back(w);
      exp_q.push_back({(((i % BL) == BL - 1) || (i == n - 1)), w});
    end
    upd_fifo();
  endtask

  // One clock: observe and score at the falling edge, then advance the FIFO model after the rising edge.
  task automatic cycle();
    logic [DATA_W:0] e;
    logic rd, acc;
    @(negedge clk);
    cyc_no++;
    if (prev_valid && !prev_ready) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
    end
    if (fifo_rd) check("credit", 32'((buf_m + inflight_m) < 2), 32'd1);
    if (busy && !busy_prev) begin
      run_cyc    = cyc_no;
      pend_first = 1'b1;
    end
    if (out_valid && pend_first) begin
      check("first_valid_lat", 32'(cyc_no - run_cyc), 32'd2);
      pend_first = 1'b0;
    end
    if (out_valid && out_ready) begin
      check("word_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data", out_data, e[31:0]);
        check("last", 32'(out_last), 32'(e[32]));
`ifdef FIFO_BURST_DRAIN_PARITY_EN
        check("parity", 32'(out_parity), 32'(^e[31:0]));
`endif
      end
    end
    rd  = fifo_rd;
    acc = out_valid && out_ready;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    busy_prev  = busy;
    @(posedge clk);
    #1;
    buf_m      = buf_m + inflight_m - int'(acc);
    inflight_m = int'(rd);
    if (rst) begin
      fifo_q.delete();
      buf_m      = 0;
      inflight_m = 0;
    end else if (rd) begin
      fifo_data = fifo_q.pop_front();
    end
    upd_fifo();
  endtask

  // mode 0: ready held high, 1: fixed toggle pattern, other: random ready.
  task automatic run_burst(input string tag, input int mode, input int max);
    logic done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ready_pat[i % 6];
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      cycle();
      done = (exp_q.size() == 0) && !busy_prev && (fifo_q.size() == 0);
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; flush = 1'b0; out_ready = 1'b0; out_ready1 = 1'b1;
    fifo_data = '0; buf_m = 0; inflight_m = 0; cyc_no = 0; run_cyc = 0;
    pend_first = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; busy_prev = 1'b0; prev_data = '0;
    upd_fifo();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(burst_cnt), 32'd0);
    check("rst_rd", 32'(fifo_rd), 32'd0);

    // Two full bursts from 0x10..0x17.
    load(8, 32'h10, 1'b0);
    run_burst("two_bursts", 0, 80);
    check("cnt_after_two", 32'(burst_cnt), 32'd2);

    // Three words without flush stay put; flush then releases a partial burst.
    load(3, 32'h20, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("noflush_rd", 32'(fifo_rd), 32'd0);
      check("noflush_busy", 32'(busy), 32'd0);
    end
    flush = 1'b1;
    run_burst("flush3", 0, 40);
    check("cnt_after_flush", 32'(burst_cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("flush_empty_idle", 32'(busy), 32'd0);
    end
    flush = 1'b0;

    // Backpressure pattern on 0xA0..0xA3.
    load(4, 32'hA0, 1'b0);
    run_burst("stall", 1, 80);
    check("cnt_after_stall", 32'(burst_cnt), 32'd4);

    // Random data and ready: 10 words give bursts of 4, 4 and a flushed 2.
    flush = 1'b1;
    load(10, 32'h0, 1'b1);
    run_burst("random", 2, 300);
    flush = 1'b0;
    check("cnt_after_random", 32'(burst_cnt), 32'd7);

    // Reset after two words of a burst are delivered.
    load(4, 32'hB0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 2; i++) cycle();
    check("pre_reset_two", 32'(exp_q.size()), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    prev_valid = 1'b0; pend_first = 1'b0; busy_prev = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rd", 32'(fifo_rd), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(burst_cnt), 32'd0);
    load(4, 32'hC0, 1'b0);
    run_burst("post_reset", 0, 40);
    check("cnt_post_reset", 32'(burst_cnt), 32'd1);

`ifdef FIFO_BURST_DRAIN_PARITY_EN
    flush = 1'b1;
    load(1, 32'h1, 1'b0);
    exp_q.delete();
    fifo_q.push_back(32'h3);
    exp_q.push_back({1'b0, 32'h1});
    exp_q.push_back({1'b1, 32'h3});
    upd_fifo();
    run_burst("parity", 0, 40);
    flush = 1'b0;
    check("cnt_parity", 32'(burst_cnt), 32'd2);
`endif

    // Burst counter wrap with single-word bursts.
    exp1 = 16'hFFFA;
    rst1 = 1'b0;
    for (int i = 0; i < 400 && exp1 != 16'd2; i++) begin
      @(negedge clk);
      check("wrap_cnt", 32'(burst_cnt1), 32'(exp1));
      if (out_valid1) check("bl1_last", 32'(out_last1), 32'd1);
      if (out_valid1 && out_ready1 && out_last1) exp1 = exp1 + 16'd1;
    end
    check("wrap_done", 32'(exp1), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
